fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage of the RV32I core. It holds the fetch PC, issues word requests to instruction memory over a request/ready + response-valid handshake, and buffers returned instructions in a small FIFO. Decode consumes the buffered instructions under a valid/ready handshake; decode and the immediate extender take their opcode and instruction fields from this block's outputs. Branch/jump redirects flush the buffer and discard any in-flight response.

Parameters:
XLEN, 32, data/address width.
RESET_PC, 32'h0000_0000, fetch PC after reset.
FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
CLK  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
imem_req  out  1  request valid.
imem_addr  out  XLEN  request word address; bits [1:0] always 00.
imem_ready  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  response data valid.
imem_rdata  in  32  response instruction word.
redirect_en  in  1  taken branch/jump, one-cycle pulse.
redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored.
if_valid  out  1  FIFO head holds an instruction.
if_ready  in  1  decode accepts the head this cycle.
if_instr  out  32  head instruction.
if_pc  out  XLEN  PC of the head instruction.
if_opcode  out  7  if_instr[6:0].

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-low (rst_n).
- Reset (rst_n low at a rising edge): fetch_pc = RESET_PC, FIFO empty, count = 0, state = FETCH. While rst_n is low: imem_req = 0, if_valid = 0.
- Empty FIFO outputs: if_instr = 32'h0000_0013 (NOP), if_pc = 0, if_opcode = 7'h13.
- FSM states: FETCH, WAIT, DROP. At most one request is outstanding.
- FETCH: imem_req = (count < FIFO_DEPTH) && !redirect_en; imem_addr = fetch_pc. If imem_req && imem_ready: go to WAIT and capture the request PC; fetch_pc += 4, wrapping modulo 2^XLEN.
- WAIT: imem_req = 0. On imem_rvalid, push {imem_rdata, request PC} into the FIFO and go to FETCH. The next request comes no earlier than the following cycle.
- DROP: imem_req = 0. On imem_rvalid, discard the data and go to FETCH.
- imem_rvalid is ignored in FETCH.
- Redirect has priority over push, pop and the state transitions above:
  - FIFO is flushed (count = 0) and fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - In FETCH: no request is issued that cycle; stay in FETCH.
  - In WAIT: if imem_rvalid is high the same cycle, the response is discarded and the state goes to FETCH; otherwise go to DROP.
  - In DROP: stay in DROP and update fetch_pc.
- Redirect latency: redirect at cycle t gives imem_req at t+1. With a 1-cycle memory, the instruction is on if_valid at t+3.
- FIFO:
  - Push happens only from WAIT. Because requests are issued only when count < FIFO_DEPTH, a push can never overflow.
  - Pop happens when if_valid && if_ready && !redirect_en.
  - Push and pop in the same cycle leave count unchanged.
  - No bypass: a pushed instruction appears on the outputs the cycle after the push.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Stall: with if_ready held low, the FIFO fills to FIFO_DEPTH and imem_req drops. Fetch resumes the cycle after the first pop.
- if_instr, if_pc and if_opcode are driven from registered FIFO storage through the head mux. There is no combinational path from imem_rdata to if_*.

Test Plan:
- Reset then run, 1-cycle memory, if_ready=1: addresses 0x0, 0x4, 0x8 issued every 2 cycles. if_pc sequence 0x0, 0x4, 0x8 with matching if_instr. First if_valid 3 cycles after reset release.
- Stall: if_ready=0 from the start. After 2 responses, count=2 and imem_req=0 with imem_addr=0x8. Raise if_ready: the pop is seen and imem_req rises the next cycle.
- Redirect in WAIT without rvalid: redirect_pc=0x100. FSM goes to DROP; the late response (0xDEADBEEF) is not pushed. Next request address is 0x100, then if_pc=0x100.
- Redirect coinciding with imem_rvalid in WAIT: data discarded, FIFO empty next cycle, next imem_addr=0x200.
- Redirect with redirect_pc=0x103 while the FIFO holds 2 entries: if_valid=0 next cycle, imem_addr=0x100. A simultaneous if_ready does not pop the post-flush state.
- fetch_pc=0xFFFF_FFFC accepted: next imem_addr=0x0000_0000. Mid-WAIT reset: state FETCH, FIFO empty, imem_addr=RESET_PC, and a late rvalid after reset is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the fetch PC and keeps at most one word request
// in flight to instruction memory. Returned words go into a small FIFO that
// decode drains under a valid/ready handshake. A redirect flushes the FIFO and
// discards any response that is still on its way back.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            CLK,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      if_opcode
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    // S_WAIT: response expected and kept; S_DROP: response expected but stale.
    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_req_pc;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [31:0]       r_instr_mem [FIFO_DEPTH];
    logic [XLEN-1:0]   r_pc_mem    [FIFO_DEPTH];

    logic              w_req;
    logic              w_fire;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [XLEN-1:0]   w_redirect_base;
    logic              w_unused_redirect_lsbs;

    // Redirect targets are word aligned; the low bits are simply dropped.
    assign w_redirect_base        = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

    // Next-state logic and the raw request decision.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = (r_count < DEPTH_C) && !redirect_en;
                if (w_req && imem_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_en) begin
                    w_state_next = imem_rvalid ? S_FETCH : S_DROP;
                end else if (imem_rvalid) begin
                    w_state_next = S_FETCH;
                end
            end
            S_DROP: begin
                if (!redirect_en && imem_rvalid) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    assign imem_req  = w_req && rst_n;
    assign imem_addr = r_fetch_pc;
    assign w_fire    = imem_req && imem_ready;
    assign w_push    = (r_state == S_WAIT) && imem_rvalid && !redirect_en;
    assign w_empty   = (r_count == '0);
    assign if_valid  = rst_n && !w_empty;
    assign w_pop     = if_valid && if_ready && !redirect_en;

    // FSM state register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch PC: redirect wins, otherwise advance by one word per accepted request.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
            r_req_pc   <= '0;
        end else if (redirect_en) begin
            r_fetch_pc <= w_redirect_base;
        end else if (w_fire) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
    end

    // FIFO occupancy and pointers; a redirect empties the buffer.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (redirect_en) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage written on each kept response.
    always_ff @(posedge CLK) begin
        // NOTE: storage has no reset; r_count alone decides which entries are meaningful.
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= imem_rdata;
            r_pc_mem[r_wr_ptr]    <= r_req_pc;
        end
    end

    // Head mux from registered storage; an empty buffer presents a NOP at PC 0.
    assign if_instr  = w_empty ? NOP : r_instr_mem[r_rd_ptr];
    assign if_pc     = w_empty ? '0  : r_pc_mem[r_rd_ptr];
    assign if_opcode = if_instr[6:0];

endmodule
